// File: rtl/ads_pkg.sv
// Shared constants and helpers for the multi-channel divider bank.
// Flattened per-channel buses are carried at a fixed maximum width so a single slicing helper serves every channel count.
package ads_pkg;

   localparam int CNT_W     = 8;
   localparam int MAX_BUS_W = 256;

   localparam logic MODE_TOGGLE = 1'b0;
   localparam logic MODE_STROBE = 1'b1;

   typedef logic [MAX_BUS_W-1:0] bus_t;

   // Extract field c of width w from a flattened bus; result is right-aligned and zero-filled.
   function automatic bus_t ch_slice(input bus_t bus, input int c, input int w);
      bus_t mask;
      mask = (bus_t'(1) << w) - bus_t'(1);
      return (bus >> (c * w)) & mask;
   endfunction

endpackage

// File: rtl/ads_div_ch.sv
// One divider channel: terminal counter, pending divisor/mode shadow, and toggle/strobe output.
// Updates land only on a terminal edge or on sync, so a period is never cut short or stretched.
module ads_div_ch #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [CNT_W-1:0] div_k,
   input  logic             mode,
   input  logic             load,
   input  logic             sync,
   input  logic [CNT_W-1:0] ph_off,
   output logic             dclk,
   output logic             tick,
   output logic             upd_pend
);
   import ads_pkg::*;

   logic [CNT_W-1:0] cnt, k_act, k_pend, k_new;
   logic             mode_act, mode_pend, mode_new, pend;
   logic [CNT_W:0]   cnt_inc;
   logic             terminal;

   // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
   always_comb begin
      cnt_inc  = {1'b0, cnt} + (CNT_W+1)'(1);
      terminal = en && (cnt_inc >= {1'b0, k_act});
      k_new    = k_act;
      mode_new = mode_act;
      // A load on the commit edge supersedes anything already pending.
      if (load) begin
         k_new    = div_k;
         mode_new = mode;
      end else if (pend) begin
         k_new    = k_pend;
         mode_new = mode_pend;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt       <= '0;
         dclk      <= 1'b0;
         tick      <= 1'b0;
         pend      <= 1'b0;
         k_act     <= div_k;
         mode_act  <= mode;
         k_pend    <= div_k;
         mode_pend <= mode;
      end else if (sync) begin
         cnt      <= ph_off;
         dclk     <= 1'b0;
         tick     <= 1'b0;
         k_act    <= k_new;
         mode_act <= mode_new;
         pend     <= 1'b0;
      end else if (terminal) begin
         cnt      <= '0;
         tick     <= 1'b1;
         k_act    <= k_new;
         mode_act <= mode_new;
         pend     <= 1'b0;
         // Switching from toggle into strobe parks dclk low; strobes start at the following terminal.
         if (mode_act == MODE_STROBE)
            dclk <= 1'b1;
         else if (mode_new == MODE_STROBE)
            dclk <= 1'b0;
         else
            dclk <= ~dclk;
      end else begin
         if (en)
            cnt <= cnt_inc[CNT_W-1:0];
         tick <= 1'b0;
         if (mode_act == MODE_STROBE)
            dclk <= 1'b0;
         if (load) begin
            k_pend    <= div_k;
            mode_pend <= mode;
            pend      <= 1'b1;
         end
      end
   end

   assign upd_pend = pend;

endmodule

// File: rtl/ads_divider_bank.sv
// Bank of N_CH independent programmable dividers sharing reset and a phase-alignment sync.
// Each channel drives one sampling phase of the downstream datapath.
module ads_divider_bank #(
   parameter int N_CH  = 3,
   parameter int CNT_W = ads_pkg::CNT_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N_CH-1:0]       en,
   input  logic [N_CH*CNT_W-1:0] div_k,
   input  logic [N_CH-1:0]       mode,
   input  logic [N_CH-1:0]       load,
   input  logic                  sync,
   input  logic [N_CH*CNT_W-1:0] ph_off,
   output logic [N_CH-1:0]       dclk,
   output logic [N_CH-1:0]       tick,
   output logic [N_CH-1:0]       upd_pend
);
   import ads_pkg::*;

   bus_t div_k_ext, ph_off_ext;

   always_comb begin
      div_k_ext                    = '0;
      ph_off_ext                   = '0;
      div_k_ext[N_CH*CNT_W-1:0]    = div_k;
      ph_off_ext[N_CH*CNT_W-1:0]   = ph_off;
   end

   for (genvar c = 0; c < N_CH; c++) begin : g_ch
      logic [CNT_W-1:0] ch_div_k, ch_ph_off;

      assign ch_div_k  = CNT_W'(ch_slice(div_k_ext, c, CNT_W));
      assign ch_ph_off = CNT_W'(ch_slice(ph_off_ext, c, CNT_W));

      ads_div_ch #(.CNT_W(CNT_W)) u_ch (
         .clk      (clk),
         .rst      (rst),
         .en       (en[c]),
         .div_k    (ch_div_k),
         .mode     (mode[c]),
         .load     (load[c]),
         .sync     (sync),
         .ph_off   (ch_ph_off),
         .dclk     (dclk[c]),
         .tick     (tick[c]),
         .upd_pend (upd_pend[c])
      );
   end

endmodule

// File: doc/ads_divider_bank.md
Name: ads_divider_bank

Overview:
- Parametrised, multi-channel successor to the single-output programmable clock divider.
- Generates N_CH independent divided outputs: 50%-duty toggle clocks or single-cycle strobes.
- Each channel's divisor and mode are updated glitch-free at period boundaries, and all channels share a common phase-alignment sync.
- Sits between the system clock and the per-phase sampling/decomposition datapath, one channel per phase (a, b, c).

Parameters:
- N_CH, 3, number of independent divider channels.
- CNT_W, 8, width of divisor, phase offset and internal counter.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  N_CH  per-channel count enable.
- div_k  in  N_CH*CNT_W  per-channel requested divisor; channel c in bits [c*CNT_W +: CNT_W].
- mode  in  N_CH  requested mode: 0 = toggle (dclk period 2K), 1 = strobe (dclk 1-cycle pulse every K).
- load  in  N_CH  1-cycle pulse; captures div_k[c] and mode[c] into the pending shadow.
- sync  in  1  1-cycle pulse; realigns all channels.
- ph_off  in  N_CH*CNT_W  per-channel counter preset applied on sync.
- dclk  out  N_CH  divided clock or strobe.
- tick  out  N_CH  1-cycle pulse at each terminal count, in either mode.
- upd_pend  out  N_CH  high while a captured divisor/mode is waiting to be committed.

Behaviour:
- Per-channel state: cnt[CNT_W], k_act, mode_act, k_pend, mode_pend, pend flag.
- Reset, checked first: cnt=0, dclk=0, tick=0, pend=0. k_act is set to div_k and mode_act to mode, both sampled in the reset cycle.
- Terminal condition: en && (cnt+1 >= k_act), compared at CNT_W+1 bits so there is no overflow.
  - k_act=0 behaves as 1: terminal every enabled cycle.
- Counting, en=1 and not terminal: cnt <= cnt+1; tick <= 0.
- Terminal edge:
  - cnt <= 0; tick <= 1 for exactly one cycle.
  - Toggle mode: dclk <= ~dclk.
  - Strobe mode: dclk <= 1, and returns to 0 on the next edge.
- Timing with K = k_act and en held high from reset release: tick is high after edges K, 2K, 3K, ...
  - Toggle: dclk high for K cycles, low for K cycles.
  - Strobe: dclk equals tick.
- en=0: cnt and dclk hold (toggle mode); tick=0; strobe dclk=0. The counter does not advance.
- load (without sync):
  - k_pend <= div_k, mode_pend <= mode, pend <= 1.
  - Commit happens at the next terminal edge: k_act <= k_pend, mode_act <= mode_pend, pend <= 0.
  - Result: no runt or stretched half-period.
- load on the same edge as a terminal: commit div_k and mode directly; pend stays 0.
- Repeated load before commit: last value wins.
- Mode change 0 -> 1 on commit while dclk=1: dclk is forced to 0 on the commit edge; strobes resume at the next terminal.
- sync (priority below rst, above all else), applied to all channels on one edge:
  - cnt <= ph_off[c], dclk <= 0, tick <= 0.
  - Any pending value or simultaneous load is committed immediately; pend <= 0.
  - ph_off >= k_act is legal: terminal on the next enabled edge.
- rst mid-period: all outputs return to reset values on that edge; pending updates are discarded.
- upd_pend = pend, registered.
- Latency: load to commit is at most k_act cycles. sync to first tick is (k_act - ph_off) enabled cycles, minimum 1.

Decomposition:
- Package ads_pkg:
  - CNT_W default.
  - Mode constants MODE_TOGGLE=0, MODE_STROBE=1.
  - Function ch_slice(bus, c) for flattened-bus extraction.
- Sub-module ads_div_ch: one channel containing counter, shadow registers and output logic.
  - Top level is a generate loop of N_CH instances; sync and rst are broadcast to all of them.

Test Plan:
- Toggle basic: rst, then k=3, mode=0, en=1 for 20 cycles -> tick after edges 3, 6, 9, ...; dclk 3 high / 3 low; period 6.
- Edge divisors: k=0 and k=1 -> tick every cycle, dclk toggles every edge; k=255 -> period 510, no counter overflow.
- Glitch-free update: k=4, load k=2 at cnt=1 -> upd_pend=1; current period completes at 4; next half-periods are 2; upd_pend drops on the commit edge.
- Strobe and en: mode=1, k=5, en low for 3 cycles mid-count -> dclk/tick 1-cycle pulses spaced 5 enabled cycles, with the gap stretched by exactly 3.
- Sync phasing: k=6 on all channels, ph_off=0/2/4, pulse sync -> ticks at 6/4/2 cycles after sync; 120-degree phase spacing held for 100 cycles.
- Collisions: load on a terminal edge commits immediately; load together with sync commits immediately; rst with sync wins; mid-period rst gives dclk=0, tick=0, upd_pend=0 on the next cycle.
